p_cacheline_arbiter: RTL and testbench
======================================

P_CACHELINE_ARBITER -- requirements
Module: p_cacheline_arbiter

Interface
REQ-001 The block SHALL have parameter LINE_W, default 256, meaning the cacheline data width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 32, meaning the byte address width in bits.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port i_read, input, 1 bit: I-cache line read request, held until i_resp.
REQ-006 The block SHALL have port i_address, input, ADDR_W bits: I-cache line address.
REQ-007 The block SHALL have port i_rdata, output, LINE_W bits: line data returned to the I-cache.
REQ-008 The block SHALL have port i_resp, output, 1 bit: I-cache transaction complete.
REQ-009 The block SHALL have ports d_read and d_write, input, 1 bit each: D-cache line read and write requests, held until d_resp.
REQ-010 The block SHALL have port d_address, input, ADDR_W bits, and port d_wdata, input, LINE_W bits: D-cache line address and writeback data.
REQ-011 The block SHALL have port d_rdata, output, LINE_W bits, and port d_resp, output, 1 bit: D-cache return data and completion.
REQ-012 The block SHALL have ports pmem_read and pmem_write, output, 1 bit each; pmem_address, output, ADDR_W bits; pmem_wdata, output, LINE_W bits: the shared memory request.
REQ-013 The block SHALL have ports pmem_rdata, input, LINE_W bits, and pmem_resp, input, 1 bit: the shared memory response.

Function
REQ-014 The FSM SHALL have states IDLE, SERVE_I, SERVE_D and DONE.
REQ-015 In IDLE with any request asserted, the block SHALL grant on the next edge and capture the winner's address and wdata (D only) into registers.
REQ-016 A request is d_read or d_write for D, and i_read for I.
REQ-017 When both requesters are pending in IDLE, the winner SHALL follow REQ-031 and REQ-032.
REQ-018 pmem_read, pmem_write, pmem_address and pmem_wdata SHALL be driven only from the captured registers and state, never combinationally from the requester inputs.
REQ-019 These outputs SHALL be held stable from the first SERVE cycle until pmem_resp.
REQ-020 In SERVE_x, the block SHALL assert the granted pmem_read or pmem_write continuously until the cycle pmem_resp=1.
REQ-021 In the cycle pmem_resp=1, x_resp SHALL be 1 for exactly one cycle, with x_rdata=pmem_rdata in that cycle; the FSM SHALL then go to DONE.
REQ-022 The non-granted requester's resp SHALL stay 0, and its rdata SHALL be 0.
REQ-023 DONE SHALL last exactly one cycle with all pmem_* strobes at 0, and SHALL then go to IDLE.
REQ-024 Minimum request-to-request spacing SHALL be: grant edge, at least one SERVE cycle, DONE, then IDLE.
REQ-025 A pmem_resp received in IDLE or DONE SHALL be ignored and SHALL not produce any x_resp.
REQ-026 If d_read and d_write are both 1 at capture, the block SHALL treat the request as a write.
REQ-027 Requests that drop before grant SHALL be ignored.
REQ-028 Requester inputs that change during SERVE SHALL have no effect.

Reset
REQ-029 While rst=1, the state SHALL be IDLE, the captured address and wdata SHALL be 0, and all outputs SHALL be 0; this holds asynchronously, including mid-SERVE.
REQ-030 An outstanding memory transaction interrupted by reset SHALL be abandoned, and a later stray pmem_resp SHALL be ignored per REQ-025.

Configuration
REQ-031 With macro P_ARB_ROUND_ROBIN_EN defined, a 1-bit priority register SHALL (a) reset to D-first and (b) flip to favour the other requester on each DONE, so that under contention grants alternate D, I, D, I.
REQ-032 Without P_ARB_ROUND_ROBIN_EN, D SHALL always win contention and no priority register SHALL exist.

Verification
REQ-033 The bench SHALL cover a single I read: i_read=1, i_address=0x0000_1000, pmem_resp after 3 cycles with pmem_rdata=0xA5..A5 -> pmem_read=1 with address 0x1000 for 3 cycles, then i_resp=1 for one cycle with i_rdata=0xA5..A5, and d_resp=0.
REQ-034 The bench SHALL cover a D writeback: d_write=1, d_address=0x8000_0040, d_wdata=pattern P -> pmem_write=1, pmem_wdata=P, pmem_read=0; d_resp pulses on pmem_resp; the next cycle is DONE with strobes 0.
REQ-035 The bench SHALL cover contention: i_read and d_read asserted in the same cycle, held, with a response after 2 cycles -> without the macro, D then I are served; with the macro, a second simultaneous round is served I-first.
REQ-036 The bench SHALL cover reset mid-transaction: rst pulsed during SERVE_D -> all outputs 0 immediately (asynchronously); a pmem_resp 2 cycles later yields no d_resp.
REQ-037 The bench SHALL cover stable outputs and stray responses: change d_address during SERVE_D -> pmem_address unchanged; pmem_resp=1 while IDLE -> no resp pulse.
REQ-038 The bench SHALL cover simultaneous strobes: d_read=d_write=1 -> pmem_write=1 and pmem_read=0.

Source files
------------

// File: rtl/p_cacheline_arbiter.sv
// p_cacheline_arbiter: shares one physical-memory port between an I-cache and
// a D-cache, one cacheline transaction at a time.
// Optional feature: define P_ARB_ROUND_ROBIN_EN for alternating priority under
// contention. In the default build the D-cache always wins contention.
module p_cacheline_arbiter #(
    parameter int LINE_W = 256,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;
    logic              wr_q, wr_d;
    logic              d_req, i_req, grant_d;

    assign d_req = d_read | d_write;
    assign i_req = i_read;

`ifdef P_ARB_ROUND_ROBIN_EN
    // prio_i_q=1 favours the I-cache; last_d_q remembers who the current
    // transaction belongs to so DONE can hand priority to the other side.
    logic prio_i_q, prio_i_d;
    logic last_d_q, last_d_d;

    assign grant_d = d_req & (~i_req | ~prio_i_q);
`else
    assign grant_d = d_req;
`endif

    // Next-state logic: grant from IDLE, wait for memory in SERVE, one DONE cycle.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wr_d    = wr_q;
`ifdef P_ARB_ROUND_ROBIN_EN
        prio_i_d = prio_i_q;
        last_d_d = last_d_q;
`endif
        case (state_q)
            IDLE: begin
                if (d_req | i_req) begin
`ifdef P_ARB_ROUND_ROBIN_EN
                    last_d_d = grant_d;
`endif
                    if (grant_d) begin
                        state_d = SERVE_D;
                        addr_d  = d_address;
                        wdata_d = d_wdata;
                        // A simultaneous read+write is treated as a writeback.
                        wr_d    = d_write;
                    end else begin
                        state_d = SERVE_I;
                        addr_d  = i_address;
                        wdata_d = '0;
                        wr_d    = 1'b0;
                    end
                end
            end
            SERVE_I, SERVE_D: begin
                if (pmem_resp) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
`ifdef P_ARB_ROUND_ROBIN_EN
                prio_i_d = last_d_q;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // State and captured-request registers; reset abandons any transaction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
`ifdef P_ARB_ROUND_ROBIN_EN
            prio_i_q <= 1'b0;
            last_d_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
`ifdef P_ARB_ROUND_ROBIN_EN
            prio_i_q <= prio_i_d;
            last_d_q <= last_d_d;
`endif
        end
    end

    // Memory request comes only from captured registers and state, so it stays
    // stable through SERVE regardless of what the requesters do.
    always_comb begin
        pmem_read    = (state_q == SERVE_I) | ((state_q == SERVE_D) & ~wr_q);
        pmem_write   = (state_q == SERVE_D) & wr_q;
        pmem_address = addr_q;
        pmem_wdata   = wdata_q;
    end

    // Completion pulses only in SERVE; responses in IDLE/DONE are ignored.
    always_comb begin
        i_resp  = (state_q == SERVE_I) & pmem_resp;
        d_resp  = (state_q == SERVE_D) & pmem_resp;
        i_rdata = i_resp ? pmem_rdata : '0;
        d_rdata = d_resp ? pmem_rdata : '0;
    end

endmodule

// File: tb/tb_p_cacheline_arbiter.sv
// Self-checking bench for p_cacheline_arbiter: directed scenarios followed by
// randomized rounds, compared against a transaction-level reference model.
module tb_p_cacheline_arbiter;
    localparam int LINE_W = 256;
    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_read;
    logic [ADDR_W-1:0] i_address;
    logic [LINE_W-1:0] i_rdata;
    logic              i_resp;
    logic              d_read, d_write;
    logic [ADDR_W-1:0] d_address;
    logic [LINE_W-1:0] d_wdata;
    logic [LINE_W-1:0] d_rdata;
    logic              d_resp;
    logic              pmem_read, pmem_write;
    logic [ADDR_W-1:0] pmem_address;
    logic [LINE_W-1:0] pmem_wdata;
    logic [LINE_W-1:0] pmem_rdata;
    logic              pmem_resp;

    int checks = 0;
    int errors = 0;

`ifdef P_ARB_ROUND_ROBIN_EN
    bit prio_i_m = 1'b0;  // model: 1 when I-cache is favoured under contention
`endif

    p_cacheline_arbiter #(.LINE_W(LINE_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
        .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [LINE_W-1:0] got, input logic [LINE_W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [LINE_W-1:0] rand_line();
        logic [LINE_W-1:0] v;
        for (int k = 0; k < LINE_W / 32; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    // Reference arbitration: lone requester wins; contention decided by policy.
    function automatic bit pick_d(input bit iq, input bit dq);
        if (!iq) return 1'b1;
        if (!dq) return 1'b0;
`ifdef P_ARB_ROUND_ROBIN_EN
        return !prio_i_m;
`else
        return 1'b1;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_i_resp"}, i_resp, 1'b0);
        chk({tag, "_d_resp"}, d_resp, 1'b0);
        chk({tag, "_i_rdata"}, i_rdata, '0);
        chk({tag, "_d_rdata"}, d_rdata, '0);
        chk({tag, "_pmem_read"}, pmem_read, 1'b0);
        chk({tag, "_pmem_write"}, pmem_write, 1'b0);
    endtask

    // One transaction from the grant edge through DONE back to IDLE.
    // Called with the DUT in IDLE and the requests already driven.
    task automatic serve(input bit ed, input logic [ADDR_W-1:0] ea, input logic [LINE_W-1:0] ew,
                         input bit ewr, input int lat, input logic [LINE_W-1:0] rd, input bit stray);
        bit last;
        tick();
        for (int c = 0; c <= lat; c++) begin
            last = (c == lat);
            pmem_resp  = last;
            pmem_rdata = last ? rd : rand_line();
            @(negedge clk);
            chk("pmem_read", pmem_read, ed ? !ewr : 1'b1);
            chk("pmem_write", pmem_write, ed & ewr);
            chk("pmem_address", pmem_address, ea);
            chk("pmem_wdata", pmem_wdata, ew);
            chk("i_resp", i_resp, !ed && last);
            chk("d_resp", d_resp, ed && last);
            chk("i_rdata", i_rdata, (!ed && last) ? rd : '0);
            chk("d_rdata", d_rdata, (ed && last) ? rd : '0);
            // Winner's inputs wander while being served; must not matter.
            if (c == 0) begin
                if (ed) begin
                    d_address = $urandom;
                    d_wdata   = rand_line();
                end else begin
                    i_address = $urandom;
                end
            end
            tick();
        end
        if (ed) begin
            d_read  = 1'b0;
            d_write = 1'b0;
        end else begin
            i_read = 1'b0;
        end
        pmem_resp  = stray;
        pmem_rdata = rand_line();
        @(negedge clk);
        chk_quiet("done");
`ifdef P_ARB_ROUND_ROBIN_EN
        prio_i_m = ed;
`endif
        tick();
        pmem_resp = 1'b0;
    endtask

    // Drive a request set, then serve the winner and (if contended) the loser.
    task automatic round(input bit iq, input bit dr, input bit dw, input logic [ADDR_W-1:0] ia,
                         input logic [ADDR_W-1:0] da, input logic [LINE_W-1:0] dwd,
                         input int lat1, input int lat2, input bit stray);
        bit first;
        bit dq;
        dq        = dr | dw;
        i_read    = iq;
        i_address = ia;
        d_read    = dr;
        d_write   = dw;
        d_address = da;
        d_wdata   = dwd;
        first = pick_d(iq, dq);
        if (first) serve(1'b1, da, dwd, dw, lat1, rand_line(), stray);
        else       serve(1'b0, ia, '0, 1'b0, lat1, rand_line(), stray);
        if (iq && dq) begin
            if (first) serve(1'b0, ia, '0, 1'b0, lat2, rand_line(), stray);
            else       serve(1'b1, da, dwd, dw, lat2, rand_line(), stray);
        end
    endtask

    initial begin
        logic [LINE_W-1:0] pat;
        rst = 1'b1;
        i_read = 0; i_address = '0;
        d_read = 0; d_write = 0; d_address = '0; d_wdata = '0;
        pmem_rdata = '0; pmem_resp = 0;

        // Reset state
        tick();
        tick();
        @(negedge clk);
        chk_quiet("reset");
        chk("reset_pmem_address", pmem_address, '0);
        chk("reset_pmem_wdata", pmem_wdata, '0);
        tick();
        rst = 1'b0;
        tick();

        // Single I read, 3 wait cycles, A5 pattern
        pat = {32{8'hA5}};
        i_read = 1'b1;
        i_address = 32'h0000_1000;
        serve(1'b0, 32'h0000_1000, '0, 1'b0, 3, pat, 1'b0);

        // D writeback
        pat = rand_line();
        round(1'b0, 1'b0, 1'b1, '0, 32'h8000_0040, pat, 2, 0, 1'b0);

        // Contention, two simultaneous rounds
        round(1'b1, 1'b1, 1'b0, 32'h0000_2000, 32'h0000_3000, rand_line(), 2, 2, 1'b0);
        round(1'b1, 1'b1, 1'b0, 32'h0000_4000, 32'h0000_5000, rand_line(), 2, 2, 1'b0);

        // Simultaneous read+write strobes -> write
        round(1'b0, 1'b1, 1'b1, '0, 32'h0000_6040, rand_line(), 1, 0, 1'b0);

        // Stray responses while IDLE, plus a request pulse that drops before grant
        for (int k = 0; k < 3; k++) begin
            pmem_resp = 1'b1;
            pmem_rdata = rand_line();
            @(negedge clk);
            chk_quiet("stray_idle");
            tick();
        end
        pmem_resp = 1'b0;
        i_read = 1'b1;
        #2;
        i_read = 1'b0;
        tick();
        @(negedge clk);
        chk_quiet("dropped_req");
        tick();

        // Reset during SERVE_D, then a late response
        d_read = 1'b1;
        d_address = 32'h0000_7000;
        tick();
        @(negedge clk);
        chk("pre_rst_pmem_read", pmem_read, 1'b1);
        #2;
        rst = 1'b1;
        d_read = 1'b0;
        #1;
        chk_quiet("async_rst");
        chk("async_rst_pmem_address", pmem_address, '0);
        chk("async_rst_pmem_wdata", pmem_wdata, '0);
`ifdef P_ARB_ROUND_ROBIN_EN
        prio_i_m = 1'b0;
`endif
        tick();
        rst = 1'b0;
        tick();
        tick();
        pmem_resp = 1'b1;
        @(negedge clk);
        chk_quiet("late_resp");
        tick();
        pmem_resp = 1'b0;

        // Randomized rounds
        for (int r = 0; r < 40; r++) begin
            bit iq, dq, dr, dw;
            iq = 1'($urandom_range(0, 1));
            dq = 1'($urandom_range(0, 1));
            if (!iq && !dq) iq = 1'b1;
            dw = dq & 1'($urandom_range(0, 1));
            dr = dq & (!dw | 1'($urandom_range(0, 1)));
            round(iq, dr, dw, $urandom, $urandom, rand_line(),
                  $urandom_range(0, 4), $urandom_range(0, 4), 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
